// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Two-source arbiter that feeds a registered 2:1 mux stage. Each cycle it
//   can accept one word from source 0 or source 1 and load it into a
//   single-entry output register. It also registers the matching mux select.
//   A tie is broken round-robin by default. Defining MUX_ARB_FIXED_PRIO_EN
//   switches to fixed priority (source 0 wins) and removes the last-grant
//   pointer. Ports and timing are the same in both builds.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   v0, d0     source-0 valid / data (mux input I0)
//   rdy0       source-0 accepted this cycle (combinational)
//   v1, d1     source-1 valid / data (mux input I1)
//   rdy1       source-1 accepted this cycle (combinational)
//   sel        registered mux select (0 = I0, 1 = I1)
//   out_valid  output register holds a word
//   out        registered selected data
//   out_ready  downstream accepts out this cycle
module mux_sel_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v0,
  input  logic [N:0]   d0,
  output logic         rdy0,
  input  logic         v1,
  input  logic [N:0]   d1,
  output logic         rdy1,
  output logic         sel,
  output logic         out_valid,
  output logic [N:0]   out,
  input  logic         out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e       state_q, state_d;
  logic         sel_q;
  logic [N:0]   out_q;
  logic         load;
  logic         win;

  // The output slot can take a new word when it is empty, or when it is
  // draining this cycle. rst masks the load so the rdy outputs stay low
  // while reset is held.
  assign load = ~rst & ((state_q == EMPTY) | out_ready) & (v0 | v1);

`ifdef MUX_ARB_FIXED_PRIO_EN
  // Source 0 always wins. Source 1 wins only when it is the only valid source.
  assign win = ~v0;
`else
  // last_q holds the most recent winner. On a tie, the other source wins.
  // It resets to 1 so that source 0 wins the first tie after reset.
  logic last_q;

  assign win = (v0 & v1) ? ~last_q : ~v0;

  always_ff @(posedge clk) begin
    if (rst)       last_q <= 1'b1;
    else if (load) last_q <= win;
  end
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    if (load)
      state_d = FULL;
    else if ((state_q == FULL) && out_ready)
      state_d = EMPTY;
  end

  // ---- output logic ----
  always_comb begin
    rdy0      = load & ~win;
    rdy1      = load &  win;
    out_valid = (state_q == FULL);
  end

  // ---- output register: select and data move together ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 1'b0;
      out_q <= '0;
    end else if (load) begin
      sel_q <= win;
      out_q <= win ? d1 : d0;
    end
  end

  assign sel = sel_q;
  assign out = out_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
module tb_mux_sel_arbiter;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         v0, v1, out_ready;
  logic [N:0]   d0, d1;
  logic         rdy0, rdy1, sel, out_valid;
  logic [N:0]   out;

  int checks = 0;
  int errors = 0;

  // Each entry is {sel, data}.
  logic [N+1:0] exp_q[$];
  logic [N+1:0] mon_e;

  mux_sel_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .v0(v0), .d0(d0), .rdy0(rdy0),
    .v1(v1), .d1(d1), .rdy1(rdy1),
    .sel(sel), .out_valid(out_valid), .out(out), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv0, input logic [N:0] id0,
                       input logic iv1, input logic [N:0] id1, input logic iordy);
    v0 = iv0; d0 = id0; v1 = iv1; d1 = id1; out_ready = iordy;
  endtask

  task automatic push(input logic [N:0] d, input logic s);
    exp_q.push_back({s, d});
  endtask

  task automatic rdy_chk(input string nm, input logic e0, input logic e1);
    chk({nm, ".rdy0"}, {31'd0, rdy0}, {31'd0, e0});
    chk({nm, ".rdy1"}, {31'd0, rdy1}, {31'd0, e1});
  endtask

  task automatic out_chk(input string nm, input logic ev, input logic [N:0] eo, input logic es);
    chk({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({nm, ".out"}, 32'(out), 32'(eo));
    chk({nm, ".sel"}, {31'd0, sel}, {31'd0, es});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every word consumed downstream must match the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got out=%0h sel=%0h expected no word", out, sel);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon.out", 32'(out), 32'(mon_e[N:0]));
          chk("mon.sel", {31'd0, sel}, {31'd0, mon_e[N+1]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic         w;
  logic [N:0]   wd;
  logic [N:0]   prev_d;
  logic         prev_s;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    tick();

    // Reset held while both sources request: nothing may be granted.
    drive(1'b1, 3'b011, 1'b1, 3'b100, 1'b1);
    repeat (2) begin
      @(negedge clk);
      out_chk("reset", 1'b0, 3'b000, 1'b0);
      rdy_chk("reset", 1'b0, 1'b0);
      tick();
    end
    rst = 1'b0;

    // Single source 0.
    drive(1'b1, 3'b011, 1'b0, '0, 1'b1);
    push(3'b011, 1'b0);
    @(negedge clk); rdy_chk("single", 1'b1, 1'b0); tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge clk); out_chk("single_out", 1'b1, 3'b011, 1'b0); rdy_chk("idle", 1'b0, 1'b0); tick();
    // Drained with no source valid: empty, data and sel held.
    @(negedge clk); out_chk("drain", 1'b0, 3'b011, 1'b0); tick();

    // Load a word, then reset before it is consumed: the word must be dropped.
    drive(1'b1, 3'b101, 1'b0, '0, 1'b0);
    push(3'b101, 1'b0);
    @(negedge clk); rdy_chk("pre_rst", 1'b1, 1'b0); tick();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk); out_chk("midrst_held", 1'b1, 3'b101, 1'b0); rdy_chk("midrst", 1'b0, 1'b0); tick();
    @(negedge clk); out_chk("midrst_clr", 1'b0, 3'b000, 1'b0); tick();
    rst = 1'b0;

    // Tie on every cycle with full drain.
    prev_d = '0; prev_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b010, 1'b1, 3'b100, 1'b1);
`ifdef MUX_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = (i % 2 == 1);
`endif
      wd = w ? 3'b100 : 3'b010;
      push(wd, w);
      @(negedge clk);
      rdy_chk("tie", ~w, w);
      if (i > 0) out_chk("tie_out", 1'b1, prev_d, prev_s);
      tick();
      prev_d = wd; prev_s = w;
    end

    // Load 110, then stall for three cycles with source 1 waiting.
    drive(1'b1, 3'b110, 1'b0, '0, 1'b1);
    push(3'b110, 1'b0);
    @(negedge clk); rdy_chk("stall_load", 1'b1, 1'b0); out_chk("tie_last", 1'b1, prev_d, prev_s); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 3'b011, 1'b0);
      @(negedge clk); rdy_chk("stall", 1'b0, 1'b0); out_chk("stall", 1'b1, 3'b110, 1'b0); tick();
    end
    drive(1'b0, '0, 1'b1, 3'b011, 1'b1);
    push(3'b011, 1'b1);
    @(negedge clk); rdy_chk("release", 1'b0, 1'b1); out_chk("release", 1'b1, 3'b110, 1'b0); tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge clk); rdy_chk("after_rel", 1'b0, 1'b0); out_chk("after_rel", 1'b1, 3'b011, 1'b1); tick();
    @(negedge clk); out_chk("drain2", 1'b0, 3'b011, 1'b1); tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter: N, default 2, data width is N+1 bits (matches the downstream 3-bit mux).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 v0  input  1  source-0 valid.
REQ-006 d0  input  N+1  source-0 data, routed to mux input I0.
REQ-007 rdy0  output  1  source-0 accepted this cycle.
REQ-008 v1  input  1  source-1 valid.
REQ-009 d1  input  N+1  source-1 data, routed to mux input I1.
REQ-010 rdy1  output  1  source-1 accepted this cycle.
REQ-011 sel  output  1  registered select for the downstream mux: 0 means I0, 1 means I1.
REQ-012 out_valid  output  1  output register holds data.
REQ-013 out  output  N+1  registered selected data.
REQ-014 out_ready  input  1  downstream consumer accepts out this cycle.

Function
REQ-015 The block SHALL implement two states, EMPTY and FULL, where out_valid = (state == FULL).
REQ-016 The load condition SHALL be: load = (EMPTY, or FULL with out_ready) AND (v0 or v1).
REQ-017 Arbitration SHALL be as follows:
- Only one source valid: that source wins.
- Both sources valid: the source not granted last wins (round-robin).
- Last-grant pointer: reset value 1, so that source 0 wins the first tie.
REQ-018 rdy0 and rdy1 SHALL be combinational, asserted only in the load cycle, only for the winner, and never both high.
REQ-019 On load, the block SHALL take these actions at the next rising edge:
- sel is set to the winner index.
- out is set to the winner's data.
- The last-grant pointer is set to the winner.
- state becomes FULL.
REQ-020 Latency: an accepted word SHALL appear on out, with out_valid high, exactly 1 cycle after its rdy pulse.
REQ-021 When state is FULL and out_ready is 0, the block SHALL hold out, sel and out_valid stable and keep rdy0 and rdy1 low.
REQ-022 When state is FULL, out_ready is 1 and neither source is valid, the next state SHALL be EMPTY, with out and sel holding their last values.
REQ-023 Simultaneous drain and load (FULL, out_ready=1, a source valid) SHALL stay in FULL, replace the data, and give full throughput of 1 word per cycle.
REQ-024 The block SHALL not use valid-in/ready-out combinational loops: rdy0 and rdy1 may depend on v0, v1 and out_ready, but out_ready SHALL not depend on rdy0 or rdy1.
REQ-025 The block SHALL produce out identical to the downstream mux's output for the registered sel, for all data values.

Reset
REQ-026 While rst is high, the block SHALL drive state=EMPTY, out_valid=0, out=0, sel=0 and last-grant=1, with rdy0 and rdy1 forced to 0.
REQ-027 Reset asserted mid-transfer SHALL discard the held word with no output handshake, and the first load after reset releases SHALL follow REQ-017.

Configuration
REQ-028 The macro MUX_ARB_FIXED_PRIO_EN SHALL control the arbitration policy:
- Defined: fixed priority applies, source 0 always wins a tie, and the last-grant pointer is not implemented.
- Undefined (default): round-robin per REQ-017.
- All ports and timing are identical in both builds.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Reset, N=2: hold rst for 2 cycles -> out_valid=0, out=000, sel=0, rdy0=rdy1=0.
- Single source: v0=1, d0=011, v1=0, out_ready=1 -> rdy0=1 that cycle; next cycle out=011, sel=0, out_valid=1.
- Tie, round-robin: v0=v1=1 every cycle, d0=010, d1=100, out_ready=1 -> out sequence 010, 100, 010, 100 and sel sequence 0, 1, 0, 1.
- Stall: FULL with out=110, out_ready=0 for 3 cycles while v1=1, d1=011 -> out stays 110, rdy1=0; with out_ready=1, out=011 one cycle later.
- Drain to empty: FULL, out_ready=1, v0=v1=0 -> out_valid=0 next cycle, out unchanged.
- MUX_ARB_FIXED_PRIO_EN defined, tie held 3 cycles -> out=d0 each cycle, sel=0, rdy1 never asserted.
